// File: rtl/scan_test_ctrl_if.sv
// Host and chain-pin bundle for scan_test_ctrl.
// master: the test host and chain side. slave: the controller.
interface scan_test_ctrl_if #(
    parameter int unsigned CHAIN_LEN = 16
) ();

    // Host request
    logic                 start;
    logic [1:0]           capture_mode;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic [CHAIN_LEN-1:0] expect_in;

    // Chain pins
    logic                 scan_data_out;
    logic                 scan_enable;
    logic                 scan_data_in;
    logic                 send_cap_en;
    logic                 recv_cap_en;

    // Status and result
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] result;

    modport master (
        output start, capture_mode, pattern_in, expect_in, scan_data_out,
        input  scan_enable, scan_data_in, send_cap_en, recv_cap_en,
        input  busy, done, pass, result
    );

    modport slave (
        input  start, capture_mode, pattern_in, expect_in, scan_data_out,
        output scan_enable, scan_data_in, send_cap_en, recv_cap_en,
        output busy, done, pass, result
    );

endinterface

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer for the 16-flop send/recv chain: load shift,
// launch/capture window, unload shift, then compare against expect.
// Optional build macro SCAN_OVERLAP_EN: a start sampled in the last unload
// cycle chains the next test, with unload shifting in the live pattern_in
// bits so the unload doubles as the next load and the DONE cycle is skipped.
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic            CK,
    input  logic            RST,
    scan_test_ctrl_if.slave bus
);

    localparam int unsigned      IDX_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [1:0]       MODE_SEND = 2'b01;
    localparam logic [1:0]       MODE_RECV = 2'b10;
    localparam logic [1:0]       MODE_BOTH = 2'b11;

`ifdef SCAN_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
    logic [CHAIN_LEN-1:0] expect_q, expect_d;
    logic [1:0]           mode_q, mode_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-1:0] result_q, result_d;
    logic                 pass_q, pass_d;
    logic                 scan_enable_q, scan_enable_d;
    logic                 sdi_q, sdi_d;
    logic                 send_q, send_d;
    logic                 recv_q, recv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [IDX_W-1:0]     idx_c;
    logic [IDX_W-1:0]     idx_nxt_c;
    logic [CHAIN_LEN-1:0] final_resp_c;

    // First capture cycle enables: {send, recv}; mode 11 launches in send first.
    function automatic logic [1:0] cap_first(input logic [1:0] m);
        return {(m == MODE_SEND) || (m == MODE_BOTH), (m == MODE_RECV)};
    endfunction

    // Bit position of the current and next shift cycle.
    assign idx_c        = cnt_q[IDX_W-1:0];
    assign idx_nxt_c    = IDX_W'(cnt_q + CNT_W'(1));
    // Full response as it will stand once the last unload bit is captured.
    assign final_resp_c = {bus.scan_data_out, shift_q[CHAIN_LEN-2:0]};

    // State register and registered outputs.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pattern_q     <= '0;
            expect_q      <= '0;
            mode_q        <= '0;
            shift_q       <= '0;
            result_q      <= '0;
            pass_q        <= 1'b0;
            scan_enable_q <= 1'b0;
            sdi_q         <= 1'b0;
            send_q        <= 1'b0;
            recv_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pattern_q     <= pattern_d;
            expect_q      <= expect_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            result_q      <= result_d;
            pass_q        <= pass_d;
            scan_enable_q <= scan_enable_d;
            sdi_q         <= sdi_d;
            send_q        <= send_d;
            recv_q        <= recv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pattern_d     = pattern_q;
        expect_d      = expect_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        result_d      = result_q;
        pass_d        = pass_q;
        scan_enable_d = 1'b0;
        sdi_d         = 1'b0;
        send_d        = 1'b0;
        recv_d        = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pattern_d     = bus.pattern_in;
                    expect_d      = bus.expect_in;
                    mode_d        = bus.capture_mode;
                    cnt_d         = '0;
                    state_d       = LOAD;
                    busy_d        = 1'b1;
                    scan_enable_d = 1'b1;
                    sdi_d         = bus.pattern_in[0];
                end
            end

            LOAD: begin
                busy_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d          = CAPTURE;
                    cnt_d            = '0;
                    {send_d, recv_d} = cap_first(mode_q);
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
                    scan_enable_d = 1'b1;
                    sdi_d         = pattern_q[idx_nxt_c];
                end
            end

            CAPTURE: begin
                busy_d = 1'b1;
                if ((mode_q == MODE_BOTH) && (cnt_q == '0)) begin
                    cnt_d  = CNT_W'(1);
                    recv_d = 1'b1;
                end else begin
                    state_d       = UNLOAD;
                    cnt_d         = '0;
                    scan_enable_d = 1'b1;
                    sdi_d         = OVERLAP ? bus.pattern_in[0] : 1'b0;
                end
            end

            UNLOAD: begin
                busy_d         = 1'b1;
                shift_d[idx_c] = bus.scan_data_out;
                if (cnt_q == LAST) begin
                    result_d = final_resp_c;
                    pass_d   = (final_resp_c == expect_q);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    if (OVERLAP && bus.start) begin
                        // Chained test: the unload just done was also its load.
                        pattern_d        = bus.pattern_in;
                        expect_d         = bus.expect_in;
                        mode_d           = bus.capture_mode;
                        state_d          = CAPTURE;
                        {send_d, recv_d} = cap_first(bus.capture_mode);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
                    scan_enable_d = 1'b1;
                    sdi_d         = OVERLAP ? bus.pattern_in[idx_nxt_c] : 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drive the bundle from the output registers.
    assign bus.scan_enable  = scan_enable_q;
    assign bus.scan_data_in = sdi_q;
    assign bus.send_cap_en  = send_q;
    assign bus.recv_cap_en  = recv_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.result       = result_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Self-checking bench for scan_test_ctrl with an identity-capture chain model.
module tb_scan_test_ctrl;

    localparam int unsigned CHAIN_LEN = 16;

    typedef struct packed {
        logic [CHAIN_LEN-1:0] res;
        logic                 pass;
    } resp_t;

    logic CK = 1'b0;
    logic RST;
    logic [CHAIN_LEN-1:0] chain = '0;

    int tests = 0;
    int fails = 0;

    resp_t exp_q[$];
    resp_t obs_q[$];

    always #5 CK = ~CK;

    scan_test_ctrl_if #(.CHAIN_LEN(CHAIN_LEN)) bus ();

    scan_test_ctrl #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(5)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    // Chain: shifts when enabled, capture leaves contents unchanged.
    always @(posedge CK) begin
        if (bus.scan_enable) chain <= {chain[CHAIN_LEN-2:0], bus.scan_data_in};
    end
    assign bus.scan_data_out = chain[CHAIN_LEN-1];

    // Observed results collected on every done pulse.
    always @(negedge CK) begin
        if (bus.done) obs_q.push_back({bus.result, bus.pass});
    end

    // Expected {scan_enable, send_cap_en, recv_cap_en, done, busy} in cycle c.
    function automatic logic [4:0] exp_ctl(input int c, input logic [1:0] m);
        int   cp;
        logic se, snd, rcv, dn, bz;
        cp  = (m == 2'b11) ? 2 : 1;
        se  = (c >= 1 && c <= 16) || (c >= 17 + cp && c <= 32 + cp);
        snd = m[0] && (c == 17);
        rcv = ((m == 2'b10) && (c == 17)) || ((m == 2'b11) && (c == 18));
        dn  = (c == 33 + cp);
        bz  = (c >= 1) && (c <= 33 + cp);
        return {se, snd, rcv, dn, bz};
    endfunction

    // Expected scan_data_in in cycle c with pattern_in held at p.
    function automatic logic exp_sdi(input int c, input logic [1:0] m, input logic [15:0] p);
        int cp;
        cp = (m == 2'b11) ? 2 : 1;
        if (c >= 1 && c <= 16) return p[4'(c - 1)];
`ifdef SCAN_OVERLAP_EN
        if (c >= 17 + cp && c <= 32 + cp) return p[4'(c - 17 - cp)];
`endif
        return 1'b0;
    endfunction

    task automatic step;
        @(posedge CK);
        #1;
    endtask

    // Present a request for one edge; leaves the bench in cycle 1.
    task automatic start_test(input logic [15:0] p, input logic [15:0] e, input logic [1:0] m);
        bus.pattern_in   = p;
        bus.expect_in    = e;
        bus.capture_mode = m;
        bus.start        = 1'b1;
        exp_q.push_back({p, (p == e)});
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        logic [22:0] outs;
        resp_t x, o;
        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        outs = {bus.scan_enable, bus.scan_data_in, bus.send_cap_en, bus.recv_cap_en,
                bus.busy, bus.done, bus.pass, bus.result};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_init outputs got %h want 0", outs);
        end
        // Complete one test so result/pass hold nonzero values before the abort.
        start_test(16'hBEEF, 16'hBEEF, 2'b01);
        repeat (39) step();
        tests++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            fails++;
            $display("FAIL reset_pre sb_count got %0d want 1", obs_q.size());
        end else begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== x) begin
                fails++;
                $display("FAIL reset_pre result got %h/%b want %h/%b", o.res, o.pass, x.res, x.pass);
            end
        end
        exp_q.delete();
        obs_q.delete();
        // Abort a running test in cycle 5 of LOAD.
        start_test(16'h1111, 16'h1111, 2'b01);
        exp_q.delete();
        repeat (4) step();
        RST = 1'b1;
        step();
        outs = {bus.scan_enable, bus.scan_data_in, bus.send_cap_en, bus.recv_cap_en,
                bus.busy, bus.done, bus.pass, bus.result};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs got %h want 0", outs);
        end
        repeat (2) step();
        RST = 1'b0;
        repeat (2) begin
            outs = {bus.scan_enable, bus.scan_data_in, bus.send_cap_en, bus.recv_cap_en,
                    bus.busy, bus.done, bus.pass, bus.result};
            tests++;
            if (outs !== '0) begin
                fails++;
                $display("FAIL reset_after outputs got %h want 0", outs);
            end
            step();
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_done_pulse count got %0d want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_capture_modes;
        logic [15:0] pats  [4];
        logic [15:0] exps  [4];
        logic [1:0]  modes [4];
        logic [4:0]  got, want;
        resp_t x, o;
        pats  = '{16'hA5C3, 16'hA5C3, 16'h0001, 16'h3C5A};
        exps  = '{16'hA5C3, 16'hA5C2, 16'h0001, 16'h3C5B};
        modes = '{2'b01, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) begin
            start_test(pats[i], exps[i], modes[i]);
            for (int c = 1; c <= 37; c++) begin
                got  = {bus.scan_enable, bus.send_cap_en, bus.recv_cap_en, bus.done, bus.busy};
                want = exp_ctl(c, modes[i]);
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL mode_ctl case %0d cyc %0d got %b want %b", i, c, got, want);
                end
                tests++;
                if (bus.scan_data_in !== exp_sdi(c, modes[i], pats[i])) begin
                    fails++;
                    $display("FAIL mode_sdi case %0d cyc %0d got %b want %b",
                             i, c, bus.scan_data_in, exp_sdi(c, modes[i], pats[i]));
                end
                step();
            end
            tests++;
            if (obs_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL mode_sb case %0d count got %0d want %0d", i, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                x = exp_q.pop_front();
                o = obs_q.pop_front();
                tests++;
                if (o !== x) begin
                    fails++;
                    $display("FAIL mode_result case %0d got %h/%b want %h/%b", i, o.res, o.pass, x.res, x.pass);
                end
            end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_busy_reject;
        logic [4:0] got, want;
        resp_t x, o;
        start_test(16'h3C5A, 16'h3C5A, 2'b00);
        for (int c = 1; c <= 40; c++) begin
            bus.start = (c == 10) || (c == 20);
            got  = {bus.scan_enable, bus.send_cap_en, bus.recv_cap_en, bus.done, bus.busy};
            want = exp_ctl(c, 2'b00);
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL busy_ctl cyc %0d got %b want %b", c, got, want);
            end
            step();
        end
        bus.start = 1'b0;
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL busy_done_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== x) begin
                fails++;
                $display("FAIL busy_result got %h/%b want %h/%b", o.res, o.pass, x.res, x.pass);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

`ifdef SCAN_OVERLAP_EN
    task automatic test_back_to_back;
        logic [4:0] got, want;
        logic       sdi_w;
        resp_t      x, o;
        start_test(16'h1234, 16'h1234, 2'b01);
        for (int c = 1; c <= 55; c++) begin
            if (c == 17) begin
                bus.pattern_in = 16'hFFFF;
                bus.expect_in  = 16'hFFFF;
            end
            if (c == 33) begin
                bus.start = 1'b1;
                exp_q.push_back({16'hFFFF, 1'b1});
            end
            if (c == 34) bus.start = 1'b0;
            got  = {bus.scan_enable, bus.send_cap_en, bus.recv_cap_en, bus.done, bus.busy};
            want = {(c >= 1 && c <= 16) || (c >= 18 && c <= 33) || (c >= 35 && c <= 50),
                    (c == 17) || (c == 34), 1'b0, (c == 34) || (c == 51), (c >= 1 && c <= 51)};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL b2b_ctl cyc %0d got %b want %b", c, got, want);
            end
            if (c >= 1 && c <= 16) sdi_w = exp_sdi(c, 2'b01, 16'h1234);
            else sdi_w = (c >= 18 && c <= 33) || (c >= 35 && c <= 50);
            tests++;
            if (bus.scan_data_in !== sdi_w) begin
                fails++;
                $display("FAIL b2b_sdi cyc %0d got %b want %b", c, bus.scan_data_in, sdi_w);
            end
            step();
        end
        tests++;
        if (obs_q.size() != 2) begin
            fails++;
            $display("FAIL b2b_sb count got %0d want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== x) begin
                fails++;
                $display("FAIL b2b_result got %h/%b want %h/%b", o.res, o.pass, x.res, x.pass);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    initial begin
        RST              = 1'b1;
        bus.start        = 1'b0;
        bus.capture_mode = 2'b00;
        bus.pattern_in   = '0;
        bus.expect_in    = '0;
        test_reset();
        test_capture_modes();
        test_busy_reject();
`ifdef SCAN_OVERLAP_EN
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
